mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port between instruction fetch (FETCH_WIDTH-word read) and the LSU (32-bit read/write).
//  One transaction is outstanding at a time; the response is routed to its owner.
//  In-flight fetch responses are discarded after a pipeline flush.
//  Sits between fetch/LSU and the bus; also emits a CSR stall-count strobe.
// PARAMETERS
//  ADDR_W   `ADDR_WIDTH                          byte address width
//  LINE_W   `INSTRUCTION_WIDTH*`FETCH_WIDTH      memory read data width
// PORTS
//  clk                   in   1       clock
//  rst                   in   1       synchronous, active-high reset
//  fetch_bus_addr        in   ADDR_W  fetch read address
//  fetch_bus_read_req    in   1       fetch read request
//  fetch_flush           in   1       commit flush (enable & flush)
//  bus_fetch_data        out  LINE_W  fetch read data
//  bus_fetch_read_ack    out  1       one-cycle fetch data valid
//  lsu_addr              in   ADDR_W  LSU address
//  lsu_req               in   1       LSU request
//  lsu_we                in   1       1 = write
//  lsu_wdata             in   32      write data
//  lsu_wmask             in   4       byte enables
//  lsu_rdata             out  32      LSU read data
//  lsu_ack               out  1       one-cycle LSU completion
//  mem_addr / mem_we / mem_wdata / mem_wmask   out   ADDR_W/1/32/4   to the memory port
//  mem_req               out  1       request to memory
//  mem_gnt               in   1       memory accepted request this cycle
//  mem_rvalid            in   1       response valid, one per accepted request, for writes as well
//  mem_rdata             in   LINE_W  response data
//  arb_csrf_fetch_stall_add  out 1    fetch requested but LSU was selected
// BEHAVIOUR
//  - State: IDLE, WAIT_RSP. Registers: owner (FETCH/LSU), drop, rr_last.
//  - Reset: state=IDLE, owner=FETCH, drop=0, rr_last=FETCH.
//  - Outputs during rst: mem_req=0, acks=0, stall_add=0.
//  - Issue window: state==IDLE, or (WAIT_RSP && mem_rvalid). This gives back-to-back issue with no bubble.
//    Outside the issue window, mem_req=0.
//  - Select: with both requesting, LSU wins (fixed priority).
//  - mem_* outputs are combinational from the selected requester.
//    Fetch drives mem_we=0, wdata=0, wmask=0.
//  - On mem_req && mem_gnt: state<=WAIT_RSP, owner<=selected.
//    No gnt: the request is not retained. The requester re-presents it next cycle with a possibly new address.
//  - Response: on mem_rvalid in WAIT_RSP the owner gets ack=1 for exactly that cycle.
//    The ack is suppressed if owner==FETCH && drop.
//    bus_fetch_data=mem_rdata. lsu_rdata=mem_rdata[31:0].
//    Then state<=IDLE, unless a new grant happens the same cycle.
//  - Flush: fetch_flush in WAIT_RSP with owner==FETCH sets drop=1.
//    If flush and rvalid coincide, that response is dropped.
//    drop clears when its response returns.
//    A fetch request granted in the flush cycle itself is NOT dropped; its address is the redirect target.
//  - Flush never affects LSU-owned transactions.
//  - rvalid while IDLE: ignored, no ack.
//  - Reset mid-transaction: return to IDLE, and the pending response is ignored.
//  - arb_csrf_fetch_stall_add = in issue window && fetch_bus_read_req && LSU selected.
// CONFIGURATION
//  MEM_ARB_RR_EN defined:
//   - Round-robin: on a conflict, grant the requester != rr_last.
//   - rr_last updates on each mem_gnt.
//  Undefined: fixed LSU priority; rr_last is not built.
// STRUCTURE
//  - Shared package (common.svh):
//    - typedef mem_owner_t {MEM_OWNER_FETCH, MEM_OWNER_LSU}
//    - typedef mem_arb_state_t {MEM_ARB_IDLE, MEM_ARB_WAIT_RSP}
//  - Sub-module mem_port_rr_select: 2-way select with the rr_last register, instantiated only under MEM_ARB_RR_EN.
// TESTING
//  1. Fetch only: req addr 0x80000000, gnt same cycle, rvalid 3 cycles later with data D.
//     -> bus_fetch_read_ack=1 for 1 cycle, data=D, lsu_ack=0.
//  2. Both request in the same cycle, fixed priority.
//     -> LSU granted, stall_add=1. Fetch granted on the LSU rvalid cycle (back-to-back), and the fetch ack follows.
//  3. Fetch in flight, fetch_flush pulse, then rvalid.
//     -> no fetch ack, drop cleared. A new fetch request at 0x80001000 in the flush cycle completes with ack=1.
//  4. LSU write 0xDEADBEEF mask 4'b0011 @0x100.
//     -> mem_we=1, wmask=0011, lsu_ack on rvalid. A fetch_flush during the write does not suppress lsu_ack.
//  5. MEM_ARB_RR_EN: both requesting continuously for 6 grants -> grants alternate LSU,FETCH,LSU,...
//  6. rst asserted in WAIT_RSP, then rvalid -> no ack, mem_req=0 during rst, state IDLE afterward.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the memory port arbiter.
// Width macros fall back to a 32-bit address / 2x32-bit fetch line when not supplied by the build.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif

package mem_port_arbiter_pkg;
  localparam int MEM_ADDR_W = `ADDR_WIDTH;
  localparam int MEM_LINE_W = `INSTRUCTION_WIDTH * `FETCH_WIDTH;

  typedef enum logic {
    MEM_OWNER_FETCH = 1'b0,
    MEM_OWNER_LSU   = 1'b1
  } mem_owner_t;

  typedef enum logic {
    MEM_ARB_IDLE     = 1'b0,
    MEM_ARB_WAIT_RSP = 1'b1
  } mem_arb_state_t;
endpackage

// File: rtl/mem_port_rr_select.sv
// Two-way round-robin select between fetch and LSU; holds the last-granted owner.
module mem_port_rr_select
  import mem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic fetch_req,
  input  logic lsu_req,
  input  logic gnt,
  output logic sel_lsu
);

  mem_owner_t rr_last_reg;

  always_comb begin
    if (fetch_req && lsu_req)
      sel_lsu = (rr_last_reg == MEM_OWNER_FETCH);
    else
      sel_lsu = lsu_req;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_last_reg <= MEM_OWNER_FETCH;
    else if (gnt)
      rr_last_reg <= sel_lsu ? MEM_OWNER_LSU : MEM_OWNER_FETCH;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int LINE_W = MEM_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_bus_addr,
  input  logic              fetch_bus_read_req,
  input  logic              fetch_flush,
  output logic [LINE_W-1:0] bus_fetch_data,
  output logic              bus_fetch_read_ack,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [31:0]       lsu_wdata,
  input  logic [3:0]        lsu_wmask,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_req,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              arb_csrf_fetch_stall_add
);

  mem_arb_state_t state_reg;
  mem_owner_t     owner_reg;
  logic           drop_reg;

  logic issue_win;
  logic rsp;
  logic sel_lsu;
  logic granted;

  assign rsp       = !rst && (state_reg == MEM_ARB_WAIT_RSP) && mem_rvalid;
  assign issue_win = (state_reg == MEM_ARB_IDLE) || rsp;
  assign mem_req   = !rst && issue_win && (fetch_bus_read_req || lsu_req);
  assign granted   = mem_req && mem_gnt;

`ifdef MEM_ARB_RR_EN
  mem_port_rr_select u_rr_select (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_bus_read_req),
    .lsu_req   (lsu_req),
    .gnt       (granted),
    .sel_lsu   (sel_lsu)
  );
`else
  assign sel_lsu = lsu_req;
`endif

  // Fetch never writes, so its write fields are forced to zero.
  assign mem_addr  = sel_lsu ? lsu_addr : fetch_bus_addr;
  assign mem_we    = sel_lsu && lsu_we;
  assign mem_wdata = sel_lsu ? lsu_wdata : 32'h0;
  assign mem_wmask = sel_lsu ? lsu_wmask : 4'h0;

  assign arb_csrf_fetch_stall_add = !rst && issue_win && fetch_bus_read_req && sel_lsu;

  // A flush arriving with the response itself also kills that response.
  assign bus_fetch_read_ack = rsp && (owner_reg == MEM_OWNER_FETCH) && !drop_reg && !fetch_flush;
  assign lsu_ack            = rsp && (owner_reg == MEM_OWNER_LSU);
  assign bus_fetch_data     = mem_rdata;
  assign lsu_rdata          = mem_rdata[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= MEM_ARB_IDLE;
      owner_reg <= MEM_OWNER_FETCH;
      drop_reg  <= 1'b0;
    end else begin
      if (granted) begin
        state_reg <= MEM_ARB_WAIT_RSP;
        owner_reg <= sel_lsu ? MEM_OWNER_LSU : MEM_OWNER_FETCH;
      end else if (rsp) begin
        state_reg <= MEM_ARB_IDLE;
      end
      // Returning response retires the drop; a fetch granted this cycle starts clean.
      if (rsp)
        drop_reg <= 1'b0;
      else if ((state_reg == MEM_ARB_WAIT_RSP) && (owner_reg == MEM_OWNER_FETCH) && fetch_flush)
        drop_reg <= 1'b1;
    end
  end

endmodule
